// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - run/set mode controller for the HH:MM:SS clock datapath
// Owns the set-mode FSM, step strobes, inc auto-repeat, idle timeout and digit blink mask.
module clock_set_ctrl #(
   parameter int BLINK_CYCLES = 25_000_000,
   parameter int HOLD_CYCLES  = 50_000_000,
   parameter int RPT_CYCLES   = 10_000_000,
   parameter int TIMEOUT_S    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       key_mode,
   input  logic       key_sel,
   input  logic       key_inc,
   input  logic       key_inc_lvl,
   output logic       run_tick,
   output logic       inc_h,
   output logic       inc_m,
   output logic       clr_s,
   output logic [5:0] blink_mask,
   output logic [1:0] mode
);

   localparam int BW = $clog2(BLINK_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int RW = $clog2(RPT_CYCLES + 1);
   localparam int IW = $clog2(TIMEOUT_S + 1);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      SET_H = 2'b01,
      SET_M = 2'b10,
      SET_S = 2'b11
   } state_t;

   state_t        state;
   logic [BW-1:0] blink_cnt;
   logic          blink_ph;
   logic [HW-1:0] hold_cnt;
   logic [RW-1:0] rpt_cnt;
   logic          repeating;
   logic [IW-1:0] idle_cnt;

   logic       in_set;
   logic       key_any;
   logic       timeout_hit;
   logic       state_chg;
   logic       inc_pulse;
   logic       rpt_en;
   logic       rpt_fire;
   logic       step_now;
   logic [5:0] sel_pair;

   assign in_set  = (state != RUN);
   assign key_any = key_mode | key_sel | key_inc;
   // Any key activity in the expiry cycle wins over the timeout.
   assign timeout_hit = in_set && (idle_cnt == IW'(TIMEOUT_S)) && !key_any && !key_inc_lvl;
   assign state_chg   = key_mode | (in_set & (key_sel | timeout_hit));
   assign inc_pulse   = in_set & key_inc & ~key_mode & ~key_sel;
   assign rpt_en      = ((state == SET_H) || (state == SET_M)) && key_inc_lvl && !state_chg;
   assign rpt_fire    = rpt_en && (repeating ? (rpt_cnt == RW'(RPT_CYCLES - 1))
                                             : (hold_cnt == HW'(HOLD_CYCLES - 1)));
   assign step_now    = inc_pulse | rpt_fire;
   assign mode        = state;

   always_comb begin
      sel_pair = 6'b000000;
      case (state)
         SET_H:   sel_pair = 6'b110000;
         SET_M:   sel_pair = 6'b001100;
         SET_S:   sel_pair = 6'b000011;
         default: sel_pair = 6'b000000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         run_tick   <= 1'b0;
         inc_h      <= 1'b0;
         inc_m      <= 1'b0;
         clr_s      <= 1'b0;
         blink_mask <= 6'b000000;
         blink_cnt  <= '0;
         blink_ph   <= 1'b0;
         hold_cnt   <= '0;
         rpt_cnt    <= '0;
         repeating  <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         run_tick <= tick_1hz && (state == RUN);
         inc_h    <= step_now && (state == SET_H);
         inc_m    <= step_now && (state == SET_M);
         clr_s    <= inc_pulse && (state == SET_S);

         case (state)
            RUN:   if (key_mode) state <= SET_H;
            SET_H: if (key_mode || timeout_hit) state <= RUN; else if (key_sel) state <= SET_M;
            SET_M: if (key_mode || timeout_hit) state <= RUN; else if (key_sel) state <= SET_S;
            default: if (key_mode || timeout_hit) state <= RUN; else if (key_sel) state <= SET_H;
         endcase

         // First strobe after the hold delay, then one per repeat period.
         if (!rpt_en) begin
            hold_cnt  <= '0;
            rpt_cnt   <= '0;
            repeating <= 1'b0;
         end else if (!repeating) begin
            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
               hold_cnt  <= '0;
               repeating <= 1'b1;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end else if (rpt_cnt == RW'(RPT_CYCLES - 1)) begin
            rpt_cnt <= '0;
         end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
         end

         if (!in_set || key_any || key_inc_lvl || timeout_hit) idle_cnt <= '0;
         else if (tick_1hz) idle_cnt <= idle_cnt + 1'b1;

         // Restarting the phase on a state change shows the new field first.
         if (state_chg) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
         end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         blink_mask <= (in_set && !key_inc_lvl && blink_ph) ? sel_pair : 6'b000000;
      end
   end

endmodule
